// File: rtl/div_pkg.sv
// Shared state type and bus-field constants for the divider request sequencer.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } div_state_t;

  // Default operand width; the divider buses are twice this wide.
  localparam int W_DEF = 8;

  // Half selectors for the 2W-wide buses: a field is [HALF*W +: W].
  // valori   = {dividend, divisor}
  // rezultat = {quotient, remainder}
  localparam int HI_HALF = 1;
  localparam int LO_HALF = 0;

  // Quotient reported for error results; sliced down to W bits where used.
  localparam logic [63:0] ERR_Q = '1;

endpackage

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO, DW wide and DEPTH deep, with an occupancy count.
// Latency: a pushed entry is visible at pop_dat on the cycle after the push.
// Backpressure: pushes while full and pops while empty are dropped internally.
module div_op_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_dat,
  input  logic                       pop,
  output logic [DW-1:0]              pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/div_req_sequencer.sv
// Feeds operand pairs from a FIFO to the divider one request at a time; results return in order.
// Latency: pop, ISSUE, divider latency, +1 to register; a zero divisor answers 1 cycle after the pop.
// Backpressure: op_ready low while the FIFO is full; results wait in HOLD for res_ready. Option: DIV_TIMEOUT_EN.
module div_req_sequencer
  import div_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [W-1:0]               op_dividend,
  input  logic [W-1:0]               op_divisor,
  output logic                       div_req,
  output logic [2*W-1:0]             div_valori,
  input  logic                       div_ack,
  input  logic [2*W-1:0]             div_rezultat,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [W-1:0]               res_quotient,
  output logic [W-1:0]               res_remainder,
  output logic                       res_err,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int  CW        = $clog2(DEPTH+1);
  localparam bit  PARAMS_OK = (W >= 1) && (W <= 64) && (DEPTH >= 2) &&
                              ((DEPTH & (DEPTH - 1)) == 0) && (TIMEOUT >= 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("div_req_sequencer: W must be 1..64, DEPTH a power of two >= 2, TIMEOUT >= 1");
  end

  div_state_t     state;
  logic           fifo_push;
  logic           fifo_pop;
  logic [2*W-1:0] head_dat;
  logic [W-1:0]   head_dividend;
  logic [W-1:0]   head_divisor;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign op_ready      = (fifo_count != CW'(DEPTH));
  assign fifo_push     = op_valid && op_ready;
  assign fifo_pop      = (state == IDLE) && (fifo_count != '0);
  assign head_dividend = head_dat[HI_HALF*W +: W];
  assign head_divisor  = head_dat[LO_HALF*W +: W];
  assign busy          = (state != IDLE);

  div_op_fifo #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (fifo_push),
    .push_dat ({op_dividend, op_divisor}),
    .pop      (fifo_pop),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

`ifdef DIV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] wait_cnt;
  logic          wait_expired;
  // The current WAIT cycle is the TIMEOUT-th one without an ack.
  assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
`endif

  // Request/response sequencer; every output here is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      div_req       <= 1'b0;
      div_valori    <= '0;
      res_valid     <= 1'b0;
      res_quotient  <= '0;
      res_remainder <= '0;
      res_err       <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      div_req <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            if (head_divisor == '0) begin
              // Answer a zero divisor locally; the divider never sees it.
              state         <= HOLD;
              res_valid     <= 1'b1;
              res_quotient  <= ERR_Q[W-1:0];
              res_remainder <= head_dividend;
              res_err       <= 1'b1;
            end else begin
              state      <= ISSUE;
              div_req    <= 1'b1;
              div_valori <= head_dat;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef DIV_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (div_ack) begin
            state         <= HOLD;
            res_valid     <= 1'b1;
            res_quotient  <= div_rezultat[HI_HALF*W +: W];
            res_remainder <= div_rezultat[LO_HALF*W +: W];
            res_err       <= 1'b0;
          end
`ifdef DIV_TIMEOUT_EN
          else if (wait_expired) begin
            state         <= HOLD;
            res_valid     <= 1'b1;
            res_quotient  <= ERR_Q[W-1:0];
            res_remainder <= '0;
            res_err       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a bench-side divider responder and result model.
// Latency: the divider responder acks DIV_LAT cycles after each request.
// Backpressure: res_ready is driven by the directed stimulus.
module tb_div_req_sequencer;

  localparam int W       = 8;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH+1);
  localparam int DIV_LAT = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           op_valid;
  logic           op_ready;
  logic [W-1:0]   op_dividend;
  logic [W-1:0]   op_divisor;
  logic           div_req;
  logic [2*W-1:0] div_valori;
  logic           div_ack;
  logic [2*W-1:0] div_rezultat;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_quotient;
  logic [W-1:0]   res_remainder;
  logic           res_err;
  logic           busy;
  logic [CW-1:0]  fifo_count;

  always #5 clk = ~clk;

  div_req_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_dividend   (op_dividend),
    .op_divisor    (op_divisor),
    .div_req       (div_req),
    .div_valori    (div_valori),
    .div_ack       (div_ack),
    .div_rezultat  (div_rezultat),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_quotient  (res_quotient),
    .res_remainder (res_remainder),
    .res_err       (res_err),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } res_t;

  res_t           expq[$];
  logic [2*W-1:0] reqq[$];
  int             checks = 0;
  int             failures = 0;
  int             results_seen = 0;
  bit             ack_en = 1'b1;
  bit             outstanding = 1'b0;
  int             countdown = 0;
  bit             prev_req = 1'b0;
  logic [2*W-1:0] cur_op;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // What the sequencer must answer for one operand pair.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    if (b == 0) begin
      m.q = '1; m.r = a; m.err = 1'b1;
    end else begin
      m.q = a / b; m.r = a % b; m.err = 1'b0;
    end
    return m;
  endfunction

  // Divider responder plus per-cycle compare against the model queues.
  initial begin
    div_ack = 1'b0;
    div_rezultat = '0;
    forever begin
      @(negedge clk);
      #3;
      div_ack = 1'b0;
      if (outstanding) begin
        countdown--;
        if (countdown == 0) begin
          outstanding = 1'b0;
          if (ack_en) begin
            div_ack = 1'b1;
            div_rezultat = {cur_op[2*W-1:W] / cur_op[W-1:0], cur_op[2*W-1:W] % cur_op[W-1:0]};
          end
        end
      end
      if (reset) begin
        expq.delete();
        reqq.delete();
        prev_req = 1'b0;
        continue;
      end
      if (div_req) begin
        check("req_single_cycle", {31'd0, prev_req}, 0);
        check("req_no_overlap", {31'd0, outstanding}, 0);
        check("req_expected", reqq.size(), (reqq.size() > 0) ? reqq.size() : 1);
        if (reqq.size() > 0) begin
          check("req_valori", div_valori, reqq[0]);
          void'(reqq.pop_front());
        end
        cur_op = div_valori;
        outstanding = 1'b1;
        countdown = DIV_LAT;
        if (!ack_en && expq.size() > 0) begin
          expq[0].q = '1; expq[0].r = '0; expq[0].err = 1'b1;
        end
      end
      prev_req = div_req;
      if (expq.size() == 0) begin
        check("res_spurious", {31'd0, res_valid}, 0);
      end else if (res_valid) begin
        check("res_quotient", res_quotient, expq[0].q);
        check("res_remainder", res_remainder, expq[0].r);
        check("res_err", res_err, expq[0].err);
        if (res_ready) begin
          void'(expq.pop_front());
          results_seen++;
        end
      end
      if (op_valid && op_ready) begin
        expq.push_back(model(op_dividend, op_divisor));
        if (op_divisor != 0) reqq.push_back({op_dividend, op_divisor});
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the push.
  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    op_valid = 1'b1; op_dividend = a; op_divisor = b;
    #1;
    while (!op_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("push_accepted", {31'd0, op_ready}, 1);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_req(output logic [2*W-1:0] v);
    int n = 0;
    bit found = 1'b0;
    v = '0;
    while (n < 300) begin
      #1;
      if (div_req) begin found = 1'b1; v = div_valori; break; end
      @(negedge clk); n++;
    end
    check("wait_req_seen", {31'd0, found}, 1);
    @(negedge clk);
  endtask

  task automatic wait_res(output res_t r, output int cyc);
    bit found = 1'b0;
    cyc = 0;
    r = '0;
    while (cyc < 300) begin
      #1;
      if (res_valid) begin
        found = 1'b1; r.q = res_quotient; r.r = res_remainder; r.err = res_err; break;
      end
      @(negedge clk); cyc++;
    end
    check("wait_res_seen", {31'd0, found}, 1);
    @(negedge clk);
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    logic [2*W-1:0] v;
    res_t r;
    int   cyc;
    int   base;
    reset = 1'b1; op_valid = 1'b0; op_dividend = '0; op_divisor = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_op_ready", {31'd0, op_ready}, 1);
    check("rst_div_req", {31'd0, div_req}, 0);
    check("rst_div_valori", div_valori, 0);
    check("rst_res_valid", {31'd0, res_valid}, 0);
    check("rst_res_quotient", res_quotient, 0);
    check("rst_res_remainder", res_remainder, 0);
    check("rst_res_err", {31'd0, res_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_fifo_count", fifo_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 100/7 -> request 16'h6407, result 14 r 2
    push_op(8'd100, 8'd7);
    wait_req(v);
    check("t1_valori", v, 16'h6407);
    wait_res(r, cyc);
    check("t1_q", r.q, 14);
    check("t1_r", r.r, 2);
    check("t1_err", {31'd0, r.err}, 0);

    // Back-to-back 255/1 and 3/9 come back in order
    push_op(8'd255, 8'd1);
    push_op(8'd3, 8'd9);
    wait_res(r, cyc);
    check("t2_first_q", r.q, 255);
    check("t2_first_r", r.r, 0);
    wait_res(r, cyc);
    check("t2_second_q", r.q, 0);
    check("t2_second_r", r.r, 3);

    // 5/0 answered locally one cycle after the pop
    push_op(8'd5, 8'd0);
    #1;
    check("t3_count_before_pop", fifo_count, 1);
    check("t3_not_yet_valid", {31'd0, res_valid}, 0);
    @(negedge clk); #1;
    check("t3_valid", {31'd0, res_valid}, 1);
    check("t3_q", res_quotient, 8'hFF);
    check("t3_r", res_remainder, 5);
    check("t3_err", {31'd0, res_err}, 1);
    @(negedge clk);

    // Six ops with the consumer stalled: one in HOLD, four queued, sixth blocked
    base = results_seen;
    res_ready = 1'b0;
    push_op(8'd20, 8'd3);
    push_op(8'd40, 8'd6);
    push_op(8'd9, 8'd0);
    push_op(8'd77, 8'd8);
    push_op(8'd250, 8'd16);
    repeat (12) @(negedge clk);
    op_valid = 1'b1; op_dividend = 8'd30; op_divisor = 8'd4;
    #1;
    check("t4_full_count", fifo_count, 4);
    check("t4_op_ready_low", {31'd0, op_ready}, 0);
    check("t4_hold_valid", {31'd0, res_valid}, 1);
    check("t4_hold_q", res_quotient, 6);
    check("t4_hold_r", res_remainder, 2);
    repeat (2) @(negedge clk);
    #1;
    check("t4_still_full", fifo_count, 4);
    check("t4_still_blocked", {31'd0, op_ready}, 0);
    @(negedge clk);
    res_ready = 1'b1;
    push_op(8'd30, 8'd4);
    cyc = 0;
    while ((expq.size() != 0 || busy) && cyc < 500) begin
      @(negedge clk); cyc++;
    end
    check("t4_drained", {31'd0, (cyc < 500)}, 1);
    check("t4_drain_count", results_seen - base, 6);

    // Reset during WAIT with ops queued; the late ack must be ignored
    push_op(8'd200, 8'd3);
    wait_req(v);
    push_op(8'd10, 8'd2);
    push_op(8'd20, 8'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("t5_res_valid", {31'd0, res_valid}, 0);
    check("t5_fifo_count", fifo_count, 0);
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_div_req", {31'd0, div_req}, 0);
    check("t5_op_ready", {31'd0, op_ready}, 1);
    @(negedge clk);

`ifdef DIV_TIMEOUT_EN
    // Ack withheld: error result after ISSUE plus 64 WAIT cycles
    ack_en = 1'b0;
    push_op(8'd50, 8'd5);
    wait_req(v);
    wait_res(r, cyc);
    check("t6_latency", cyc + 1, 65);
    check("t6_q", r.q, 8'hFF);
    check("t6_r", r.r, 0);
    check("t6_err", {31'd0, r.err}, 1);
    ack_en = 1'b1;
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
